// File: rtl/memory_access_stage_if.sv
// ============================================================================
//  Module   : memory_access_stage_if
//  Purpose  : Data-memory request/response bus between the MEM stage and the
//             data memory. Read data is valid in the cycle mem_ack is high.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    // Pipeline stage side: issues requests, receives acknowledges
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/memory_access_stage.sv
// ============================================================================
//  Module   : memory_access_stage
//  Purpose  : Pipeline MEM stage. Latches the Execute result, performs an
//             optional data-memory access with an ack timeout, and presents a
//             one-cycle writeback / branch-resolution pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,

    input  wire logic            in_valid,
    input  wire logic [15:0]     ALU_Result,
    input  wire logic [15:0]     adder_result,
    input  wire logic            Zero,
    input  wire logic [2:0]      mux_rd_rt_out,
    input  wire logic [15:0]     write_data,
    input  wire logic            MemRead,
    input  wire logic            MemWrite,
    input  wire logic            Branch,
    input  wire logic            MemtoReg,
    input  wire logic            RegWrite,

    output logic                 stall_out,

    memory_access_stage_if.master mem,

    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [2:0]           wb_rd,
    output logic [15:0]          wb_data,
    output logic                 PCSrc,
    output logic [15:0]          branch_target,
    output logic                 mem_error
);

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  c_CNT_ONE = CW'(1);

    localparam logic [0:0]     c_IDLE    = 1'b0;
    localparam logic [0:0]     c_ACCESS  = 1'b1;

    logic [0:0]     r_state;
    logic [CW-1:0]  r_wait_cnt;

    // EX/MEM pipeline register
    logic [15:0]    r_alu_result;
    logic [15:0]    r_adder_result;
    logic           r_zero;
    logic [2:0]     r_rd;
    logic [15:0]    r_write_data;
    logic           r_mem_write;
    logic           r_branch;
    logic           r_mem_to_reg;
    logic           r_reg_write;

    logic           w_in_access;

    // Request signals come straight from the state and the latched operands,
    // so they cannot change while the request is outstanding.
    always_comb begin
        w_in_access   = (r_state == c_ACCESS);
        stall_out     = w_in_access;
        mem.mem_req   = w_in_access;
        mem.mem_we    = w_in_access & r_mem_write;
        mem.mem_addr  = r_alu_result;
        mem.mem_wdata = r_write_data;
        branch_target = r_adder_result;
    end

    // Stage sequencing: accept in IDLE, wait for ack or timeout in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_wait_cnt     <= '0;
            r_alu_result   <= '0;
            r_adder_result <= '0;
            r_zero         <= 1'b0;
            r_rd           <= '0;
            r_write_data   <= '0;
            r_mem_write    <= 1'b0;
            r_branch       <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_reg_write    <= 1'b0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            PCSrc          <= 1'b0;
            mem_error      <= 1'b0;
        end else begin
            // Pulses default low; only a completing instruction raises them
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            PCSrc        <= 1'b0;
            mem_error    <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_alu_result   <= ALU_Result;
                        r_adder_result <= adder_result;
                        r_zero         <= Zero;
                        r_rd           <= mux_rd_rt_out;
                        r_write_data   <= write_data;
                        r_mem_write    <= MemWrite;
                        r_branch       <= Branch;
                        r_mem_to_reg   <= MemtoReg;
                        r_reg_write    <= RegWrite;
                        if (MemRead || MemWrite) begin
                            r_state    <= c_ACCESS;
                            r_wait_cnt <= '0;
                        end else begin
                            // Non-memory op completes in the very next cycle
                            wb_valid     <= 1'b1;
                            wb_reg_write <= RegWrite;
                            wb_rd        <= mux_rd_rt_out;
                            wb_data      <= ALU_Result;
                            PCSrc        <= Branch & Zero;
                        end
                    end
                end

                c_ACCESS: begin
                    if (mem.mem_ack) begin
                        // Ack beats a simultaneous timeout. Writes (including
                        // MemRead+MemWrite) discard the returned data.
                        r_state      <= c_IDLE;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= r_reg_write;
                        wb_rd        <= r_rd;
                        wb_data      <= (r_mem_to_reg && !r_mem_write) ?
                                        mem.mem_rdata : r_alu_result;
                        PCSrc        <= r_branch & r_zero;
                    end else if (r_wait_cnt == c_CNT_MAX) begin
                        // Abort: report the error, suppress the register write
                        r_state      <= c_IDLE;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                        wb_rd        <= r_rd;
                        wb_data      <= r_alu_result;
                        PCSrc        <= r_branch & r_zero;
                        mem_error    <= 1'b1;
                    end else begin
                        r_wait_cnt   <= r_wait_cnt + c_CNT_ONE;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
